// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I control unit (IR, FSM, wait timeout, retire count).
// Build option ILLEGAL_TRAP_EN: illegal encodings trap to ERR and raise illegal_insn.
module multicycle_control #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned RET_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    input  logic             BrEq,
    input  logic             BrLT,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [3:0]       ALUControl,
    output logic [2:0]       LControl,
    output logic [1:0]       SControl,
    output logic             ASel,
    output logic             ALUSrc,
    output logic [1:0]       WBSel,
    output logic             BrUn,
    output logic             pc_write,
    output logic             pc_sel,
    output logic [31:0]      ir,
    output logic             busy,
    output logic             bus_err,
`ifdef ILLEGAL_TRAP_EN
    output logic             illegal_insn,
`endif
    output logic [RET_W-1:0] retired
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [7:0]  WAIT_MAX = 8'(WAIT_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [7:0]       wait_q, wait_d;
    logic [RET_W-1:0] ret_q, ret_d;
    logic             berr_q, berr_d;
`ifdef ILLEGAL_TRAP_EN
    logic             ill_q, ill_d;
`endif

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_op, is_opi, is_lui, is_auipc, is_jal, is_jalr;
    logic       is_load, is_store, is_br;
    logic       legal, taken, timeout;
    logic [3:0] alu_op;
    logic [2:0] ld_ctl;

    assign opc      = ir_q[6:0];
    assign f3       = ir_q[14:12];
    assign f7       = ir_q[31:25];
    assign is_op    = opc == OPC_OP;
    assign is_opi   = opc == OPC_OPI;
    assign is_lui   = opc == OPC_LUI;
    assign is_auipc = opc == OPC_AUIPC;
    assign is_jal   = opc == OPC_JAL;
    assign is_jalr  = opc == OPC_JALR;
    assign is_load  = opc == OPC_LOAD;
    assign is_store = opc == OPC_STORE;
    assign is_br    = opc == OPC_BR;

    // funct3[2] picks LT vs EQ, funct3[0] inverts (BNE/BGE/BGEU)
    assign taken   = (f3[2] ? BrLT : BrEq) ^ f3[0];
    assign timeout = !mem_ready && (wait_q == WAIT_MAX);

    always_comb begin
        legal = 1'b0;
        case (opc)
            OPC_OP:    legal = (f7 == 7'h00) ||
                               (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            OPC_OPI:   legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                               (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            OPC_LUI,
            OPC_AUIPC,
            OPC_JAL:   legal = 1'b1;
            OPC_JALR:  legal = f3 == 3'd0;
            OPC_LOAD:  legal = f3 != 3'd3 && f3 < 3'd6;
            OPC_STORE: legal = f3 < 3'd3;
            OPC_BR:    legal = f3 != 3'd2 && f3 != 3'd3;
            default:   legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        if (is_op || is_opi) begin
            case (f3)
                3'd0: alu_op = (is_op && f7[5]) ? ALU_SUB : ALU_ADD;
                3'd1: alu_op = ALU_SLL;
                3'd2: alu_op = ALU_SLT;
                3'd3: alu_op = ALU_SLTU;
                3'd4: alu_op = ALU_XOR;
                3'd5: alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                3'd6: alu_op = ALU_OR;
                3'd7: alu_op = ALU_AND;
            endcase
        end
    end

    always_comb begin
        ld_ctl = 3'b000;
        case (f3)
            3'd1:    ld_ctl = 3'b001;
            3'd2:    ld_ctl = 3'b010;
            3'd4:    ld_ctl = 3'b011;
            3'd5:    ld_ctl = 3'b100;
            default: ld_ctl = 3'b000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        ret_d   = ret_q;
        berr_d  = berr_q;
`ifdef ILLEGAL_TRAP_EN
        ill_d   = ill_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                wait_d  = 8'd0;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                    wait_d  = 8'd0;
                end else if (timeout) begin
                    berr_d  = 1'b1;
                    state_d = S_ERR;
                end else begin
                    wait_d  = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    ill_d   = 1'b1;
                    state_d = S_ERR;
`else
                    state_d = S_FETCH;
                    wait_d  = 8'd0;
`endif
                end
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                    wait_d  = 8'd0;
                end else if (is_br) begin
                    ret_d   = ret_q + RET_W'(1);
                    state_d = S_FETCH;
                    wait_d  = 8'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    wait_d = 8'd0;
                    if (is_store) begin
                        ret_d   = ret_q + RET_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    berr_d  = 1'b1;
                    state_d = S_ERR;
                end else begin
                    wait_d  = wait_q + 8'd1;
                end
            end
            S_WB: begin
                ret_d   = ret_q + RET_W'(1);
                state_d = S_FETCH;
                wait_d  = 8'd0;
            end
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= NOP;
            wait_q  <= 8'd0;
            ret_q   <= '0;
            berr_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            ill_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            ret_q   <= ret_d;
            berr_q  <= berr_d;
`ifdef ILLEGAL_TRAP_EN
            ill_q   <= ill_d;
`endif
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ALUControl = ALU_ADD;
        LControl   = 3'b000;
        SControl   = 2'b00;
        ASel       = 1'b0;
        ALUSrc     = 1'b0;
        WBSel      = 2'b00;
        BrUn       = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        case (state_q)
            S_FETCH: mem_req = 1'b1;
            S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
                pc_write = !legal;
`endif
            end
            S_EXEC: begin
                ALUControl = alu_op;
                ASel       = is_auipc || is_jal || is_br;
                ALUSrc     = !is_op;
                BrUn       = is_br && f3[1];
                pc_write   = is_br;
                pc_sel     = is_br && taken;
            end
            S_MEM: begin
                // address operands stay applied for the whole access
                mem_req  = 1'b1;
                MemWrite = is_store;
                ALUSrc   = 1'b1;
                LControl = is_load ? ld_ctl : 3'b000;
                SControl = is_store ? f3[1:0] : 2'b00;
                pc_write = is_store && mem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                LControl = is_load ? ld_ctl : 3'b000;
                WBSel    = is_load ? 2'b01 :
                           (is_jal || is_jalr) ? 2'b10 :
                           is_lui ? 2'b11 : 2'b00;
                pc_write = 1'b1;
                pc_sel   = is_jal || is_jalr;
            end
            default: ;
        endcase
    end

    assign ir      = ir_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_ERR);
    assign bus_err = berr_q;
    assign retired = ret_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_insn = ill_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized self-checking bench for multicycle_control.
// Expected controls come from a per-instruction-class model of the ISA rules.
module tb_multicycle_control;

    localparam int WL = 15;
    localparam int RW = 5;

    typedef enum int {
        K_OP, K_OPI, K_LUI, K_AUIPC, K_JAL, K_JALR, K_LOAD, K_STORE, K_BR
    } kind_e;

    typedef struct packed {
        logic       mr;
        logic       mw;
        logic       rw;
        logic [3:0] alu;
        logic [2:0] lc;
        logic [1:0] sc;
        logic       as;
        logic       bs;
        logic [1:0] wb;
        logic       bu;
        logic       pw;
        logic       ps;
        logic       bz;
    } ctl_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   mem_rdata = 32'd0;
    logic          mem_ready = 1'b0;
    logic          BrEq = 1'b0;
    logic          BrLT = 1'b0;
    logic          mem_req, MemWrite, RegWrite;
    logic [3:0]    ALUControl;
    logic [2:0]    LControl;
    logic [1:0]    SControl;
    logic          ASel, ALUSrc, BrUn, pc_write, pc_sel, busy, bus_err;
    logic [1:0]    WBSel;
    logic [31:0]   ir;
    logic [RW-1:0] retired;
`ifdef ILLEGAL_TRAP_EN
    logic          illegal_insn;
`endif

    ctl_t obs;
    int   tests = 0;
    int   fails = 0;
    int   exp_ret = 0;

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_LIMIT(WL), .RET_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .BrEq(BrEq), .BrLT(BrLT),
        .mem_req(mem_req), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .LControl(LControl), .SControl(SControl),
        .ASel(ASel), .ALUSrc(ALUSrc), .WBSel(WBSel), .BrUn(BrUn),
        .pc_write(pc_write), .pc_sel(pc_sel), .ir(ir),
        .busy(busy), .bus_err(bus_err),
`ifdef ILLEGAL_TRAP_EN
        .illegal_insn(illegal_insn),
`endif
        .retired(retired)
    );

    assign obs = {mem_req, MemWrite, RegWrite, ALUControl, LControl, SControl,
                  ASel, ALUSrc, WBSel, BrUn, pc_write, pc_sel, busy};

    // ALU op required by the ISA for the given instruction
    function automatic logic [3:0] exp_alu(input kind_e k, input logic [31:0] insn);
        logic [2:0] f3;
        f3 = insn[14:12];
        if (k != K_OP && k != K_OPI) return 4'd0;
        if (k == K_OP && f3 == 3'd0 && insn[30]) return 4'd1;
        if (f3 == 3'd5 && insn[30]) return 4'd7;
        case (f3)
            3'd0: return 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [2:0] exp_lc(input logic [2:0] f3);
        case (f3)
            3'd0: return 3'd0;
            3'd1: return 3'd1;
            3'd2: return 3'd2;
            3'd4: return 3'd3;
            3'd5: return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [31:0] gen(input kind_e k);
        logic [31:0] r;
        logic [2:0]  f3;
        logic [6:0]  f7;
        r  = $urandom;
        f3 = r[14:12];
        f7 = 7'h00;
        case (k)
            K_OP: begin
                if ((f3 == 3'd0 || f3 == 3'd5) && r[30]) f7 = 7'h20;
                return {f7, r[24:15], f3, r[11:7], 7'b0110011};
            end
            K_OPI: begin
                if (f3 == 3'd5) f7 = r[30] ? 7'h20 : 7'h00;
                else if (f3 != 3'd1) f7 = r[31:25];
                return {f7, r[24:15], f3, r[11:7], 7'b0010011};
            end
            K_LUI:   return {r[31:7], 7'b0110111};
            K_AUIPC: return {r[31:7], 7'b0010111};
            K_JAL:   return {r[31:7], 7'b1101111};
            K_JALR:  return {r[31:15], 3'b000, r[11:7], 7'b1100111};
            K_LOAD: begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
                return {r[31:15], f3, r[11:7], 7'b0000011};
            end
            K_STORE: begin
                f3 = 3'($urandom_range(0, 2));
                return {r[31:15], f3, r[11:7], 7'b0100011};
            end
            default: begin
                if (f3 == 3'd2 || f3 == 3'd3) f3 = f3 + 3'd2;
                return {r[31:15], f3, r[11:7], 7'b1100011};
            end
        endcase
    endfunction

    // Runs one instruction from its first FETCH cycle; beq_f/blt_f < 0 means random.
    task automatic do_insn(input logic [31:0] insn, input kind_e k, input int fd,
                           input int md, input logic illegal,
                           input int beq_f, input int blt_f);
        ctl_t       e;
        logic [2:0] f3;
        logic       beq, blt, taken;
        f3 = insn[14:12];
        for (int c = 0; c <= fd; c++) begin
            @(negedge clk);
            mem_ready = (c == fd);
            mem_rdata = (c == fd) ? insn : $urandom;
            BrEq = 1'($urandom);
            BrLT = 1'($urandom);
            #1;
            if (c == 0) begin
                tests++;
                if (retired !== RW'(exp_ret)) begin
                    fails++;
                    $display("FAIL retired: got %0d want %0d", retired, RW'(exp_ret));
                end
            end
            e = '0; e.mr = 1'b1; e.bz = 1'b1;
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL fetch %h: got %h want %h", insn, obs, e);
            end
        end
        @(negedge clk);
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        #1;
        tests++;
        if (ir !== insn) begin
            fails++;
            $display("FAIL ir: got %h want %h", ir, insn);
        end
        e = '0; e.bz = 1'b1;
`ifndef ILLEGAL_TRAP_EN
        e.pw = illegal;
`endif
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL decode %h: got %h want %h", insn, obs, e);
        end
        if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
            @(negedge clk);
            #1;
            tests++;
            if (obs !== '0 || illegal_insn !== 1'b1 || bus_err !== 1'b0) begin
                fails++;
                $display("FAIL trap %h: got %h/%b/%b want 0/1/0",
                         insn, obs, illegal_insn, bus_err);
            end
`endif
            return;
        end
        @(negedge clk);
        beq = (beq_f < 0) ? 1'($urandom) : beq_f[0];
        blt = (blt_f < 0) ? 1'($urandom) : blt_f[0];
        BrEq = beq;
        BrLT = blt;
        mem_ready = 1'($urandom);
        #1;
        case (f3)
            3'd0:         taken = beq;
            3'd1:         taken = !beq;
            3'd4, 3'd6:   taken = blt;
            default:      taken = !blt;
        endcase
        e = '0; e.bz = 1'b1;
        e.alu = exp_alu(k, insn);
        e.as = (k == K_AUIPC || k == K_JAL || k == K_BR);
        e.bs = (k != K_OP);
        e.bu = (k == K_BR) && (f3 == 3'd6 || f3 == 3'd7);
        e.pw = (k == K_BR);
        e.ps = (k == K_BR) && taken;
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL exec %h: got %h want %h", insn, obs, e);
        end
        if (k == K_BR) begin
            exp_ret = (exp_ret + 1) % (1 << RW);
            return;
        end
        if (k == K_LOAD || k == K_STORE) begin
            for (int c = 0; c <= md; c++) begin
                @(negedge clk);
                mem_ready = (c == md);
                BrEq = 1'($urandom);
                #1;
                e = '0; e.bz = 1'b1; e.mr = 1'b1; e.bs = 1'b1;
                e.mw = (k == K_STORE);
                e.lc = (k == K_LOAD) ? exp_lc(f3) : 3'd0;
                e.sc = (k == K_STORE) ? f3[1:0] : 2'd0;
                e.pw = (k == K_STORE) && (c == md);
                tests++;
                if (obs !== e) begin
                    fails++;
                    $display("FAIL mem %h cyc %0d: got %h want %h", insn, c, obs, e);
                end
            end
            if (k == K_STORE) begin
                exp_ret = (exp_ret + 1) % (1 << RW);
                return;
            end
        end
        @(negedge clk);
        mem_ready = 1'($urandom);
        #1;
        e = '0; e.bz = 1'b1; e.rw = 1'b1; e.pw = 1'b1;
        e.ps = (k == K_JAL || k == K_JALR);
        e.lc = (k == K_LOAD) ? exp_lc(f3) : 3'd0;
        case (k)
            K_LOAD:         e.wb = 2'b01;
            K_JAL, K_JALR:  e.wb = 2'b10;
            K_LUI:          e.wb = 2'b11;
            default:        e.wb = 2'b00;
        endcase
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL wb %h: got %h want %h", insn, obs, e);
        end
        exp_ret = (exp_ret + 1) % (1 << RW);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = $urandom;
        #1;
        tests++;
        if (obs !== '0 || ir !== 32'h00000013 || retired !== '0 || bus_err !== 1'b0) begin
            fails++;
            $display("FAIL reset: got %h ir=%h ret=%0d berr=%b", obs, ir, retired, bus_err);
        end
`ifdef ILLEGAL_TRAP_EN
        tests++;
        if (illegal_insn !== 1'b0) begin
            fails++;
            $display("FAIL reset illegal_insn: got %b want 0", illegal_insn);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL idle: got %h want 0", obs);
        end
        exp_ret = 0;
    endtask

    task automatic test_plan();
        test_reset();
        do_insn(32'h002081B3, K_OP, 0, 0, 1'b0, -1, -1);
        do_insn(32'h0080A283, K_LOAD, 0, 2, 1'b0, -1, -1);
        do_insn(32'h00209223, K_STORE, 1, 1, 1'b0, -1, -1);
        do_insn(32'h00209463, K_BR, 0, 0, 1'b0, 1, 0);
        do_insn(32'h00209463, K_BR, 0, 0, 1'b0, 0, 0);
        do_insn(32'h0020E463, K_BR, 0, 0, 1'b0, 0, 1);
    endtask

    task automatic test_random();
        kind_e k;
        for (int i = 0; i < 60; i++) begin
            k = kind_e'($urandom_range(0, 8));
            do_insn(gen(k), k, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'b0, -1, -1);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [5];
        bad[0] = {25'd0, 7'b1111111};
        bad[1] = {17'd0, 3'b110, 5'd5, 7'b0000011};
        bad[2] = {17'd0, 3'b011, 5'd4, 7'b0100011};
        bad[3] = {7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        bad[4] = {7'h20, 5'd3, 5'd1, 3'b001, 5'd3, 7'b0010011};
        for (int i = 0; i < 5; i++) begin
`ifdef ILLEGAL_TRAP_EN
            test_reset();
`endif
            do_insn(bad[i], K_OP, $urandom_range(0, 2), 0, 1'b1, -1, -1);
        end
`ifndef ILLEGAL_TRAP_EN
        do_insn(32'h002081B3, K_OP, 0, 0, 1'b0, -1, -1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        tests++;
        if (retired !== RW'(exp_ret)) begin
            fails++;
            $display("FAIL nop retired: got %0d want %0d", retired, RW'(exp_ret));
        end
`endif
    endtask

    task automatic test_timeout();
        test_reset();
        for (int c = 0; c < WL; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            tests++;
            if (mem_req !== 1'b1 || busy !== 1'b1 || bus_err !== 1'b0) begin
                fails++;
                $display("FAIL wait cyc %0d: got req=%b busy=%b berr=%b want 1/1/0",
                         c, mem_req, busy, bus_err);
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
            #1;
            tests++;
            if (bus_err !== 1'b1 || obs !== '0) begin
                fails++;
                $display("FAIL err cyc %0d: got berr=%b ctl=%h want 1/0", c, bus_err, obs);
            end
        end
        test_reset();
    endtask

    task automatic test_reset_mid_mem();
        test_reset();
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 32'h00209223;
        #1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        tests++;
        if (MemWrite !== 1'b1 || mem_req !== 1'b1) begin
            fails++;
            $display("FAIL mid-mem: got mw=%b req=%b want 1/1", MemWrite, mem_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== '0 || retired !== '0) begin
            fails++;
            $display("FAIL abort: got %h ret=%0d want 0", obs, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_ret = 0;
        do_insn(32'h00209223, K_STORE, 0, 0, 1'b0, -1, -1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        tests++;
        if (retired !== RW'(1)) begin
            fails++;
            $display("FAIL recover retired: got %0d want 1", retired);
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
